// File: rtl/alu_multicycle.sv
// Execute-stage integer ALU with valid/ready handshake: single-cycle ALU/branch ops,
// plus iterative shift-add multiply and restoring divide (1 bit per cycle).
module alu_multicycle #(
    parameter int XLEN      = 32,
    parameter int OP_WIDTH  = 5,
    parameter int TAG_WIDTH = 5,
    parameter int SHAMT_W   = $clog2(XLEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  in_op,
    input  logic [XLEN-1:0]      in_a,
    input  logic [XLEN-1:0]      in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic                 out_flag,
    output logic [TAG_WIDTH-1:0] out_tag
);
    localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_NOR    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_BEQ    = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_BNE    = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_BLT    = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_BGE    = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_BLTU   = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_BGEU   = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(19);
    localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(20);
    localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(21);
    localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(22);
    localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(23);
    localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(24);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    state_t                 state_q, state_d;
    logic [SHAMT_W-1:0]     count_q, count_d;
    logic [XLEN-1:0]        res_q, res_d;
    logic                   flag_q, flag_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [OP_WIDTH-1:0]    op_q, op_d;
    logic [XLEN-1:0]        hi_q, hi_d, lo_q, lo_d, bm_q, bm_d;
    logic                   negq_q, negq_d, negr_q, negr_d;

    logic signed [XLEN-1:0] a_s, b_s;
    logic [XLEN-1:0]        diff, alu_res, fast_res, a_mag, b_mag;
    logic                   alu_flag, lt_s, lt_u, eq;
    logic                   is_mul, is_div, a_sgn, b_sgn, div_fast, accept;
    logic [SHAMT_W-1:0]     shamt;

    assign a_s   = in_a;
    assign b_s   = in_b;
    assign diff  = in_a - in_b;
    assign lt_s  = a_s < b_s;
    assign lt_u  = in_a < in_b;
    assign eq    = (in_a == in_b);
    assign shamt = in_b[SHAMT_W-1:0];

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  begin alu_res = diff; alu_flag = (diff == '0); end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRL:  alu_res = in_a >> shamt;
            OP_SRA:  alu_res = a_s >>> shamt;
            OP_SLT:  begin alu_res = {{(XLEN-1){1'b0}}, lt_s}; alu_flag = lt_s; end
            OP_SLTU: begin alu_res = {{(XLEN-1){1'b0}}, lt_u}; alu_flag = lt_u; end
            OP_BEQ:  alu_flag = eq;
            OP_BNE:  alu_flag = !eq;
            OP_BLT:  alu_flag = lt_s;
            OP_BGE:  alu_flag = !lt_s;
            OP_BLTU: alu_flag = lt_u;
            OP_BGEU: alu_flag = !lt_u;
            default: ;
        endcase
    end

    // Operand signedness decides whether iteration runs on magnitudes with a sign fix.
    assign is_mul   = in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div   = in_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign a_sgn    = (in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && in_a[XLEN-1];
    assign b_sgn    = (in_op inside {OP_MULH, OP_DIV, OP_REM}) && in_b[XLEN-1];
    assign a_mag    = cond_neg(in_a, a_sgn);
    assign b_mag    = cond_neg(in_b, b_sgn);
    assign div_fast = (in_b == '0) ||
                      ((in_op inside {OP_DIV, OP_REM}) &&
                       in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1);

    always_comb begin
        if (in_b == '0)
            fast_res = (in_op inside {OP_DIV, OP_DIVU}) ? '1 : in_a;
        else
            fast_res = (in_op == OP_DIV) ? in_a : '0;
    end

    // One shift-add multiply step and one restoring-divide step on the shared registers.
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN-1:0]   div_trial, div_rem_n, div_quo_n;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_prod;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bm_q} : '0);
    assign mul_prod  = cond_neg2({mul_sum, lo_q[XLEN-1:1]}, negq_q);
    assign div_sh    = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = div_sh >= {1'b0, bm_q};
    assign div_trial = div_sh[XLEN-1:0] - bm_q;
    assign div_rem_n = div_ge ? div_trial : div_sh[XLEN-1:0];
    assign div_quo_n = {lo_q[XLEN-2:0], div_ge};

    assign in_ready = !rst && !flush &&
                      (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        res_d   = res_q;
        flag_d  = flag_q;
        tag_d   = tag_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        bm_d    = bm_q;
        negq_d  = negq_q;
        negr_d  = negr_q;

        case (state_q)
            S_MUL: begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                if (count_q == '0) begin
                    res_d   = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
                    flag_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q - SHAMT_W'(1);
                end
            end
            S_DIV: begin
                hi_d = div_rem_n;
                lo_d = div_quo_n;
                if (count_q == '0) begin
                    res_d   = (op_q inside {OP_DIV, OP_DIVU}) ? cond_neg(div_quo_n, negq_q)
                                                              : cond_neg(div_rem_n, negr_q);
                    flag_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q - SHAMT_W'(1);
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: ;
        endcase

        if (accept) begin
            op_d   = in_op;
            tag_d  = in_tag;
            negq_d = a_sgn ^ b_sgn;
            negr_d = a_sgn;
            hi_d   = '0;
            if (is_mul) begin
                state_d = S_MUL;
                count_d = SHAMT_W'(XLEN-1);
                lo_d    = b_mag;
                bm_d    = a_mag;
            end else if (is_div && !div_fast) begin
                state_d = S_DIV;
                count_d = SHAMT_W'(XLEN-1);
                lo_d    = a_mag;
                bm_d    = b_mag;
            end else begin
                state_d = S_DONE;
                res_d   = is_div ? fast_res : alu_res;
                flag_d  = is_div ? 1'b0 : alu_flag;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
            tag_q   <= tag_d;
        end
    end

    // Iteration datapath carries no reset; it is always reloaded on accept.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        bm_q   <= bm_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
    end

    assign out_valid  = (state_q == S_DONE);
    assign out_result = res_q;
    assign out_flag   = flag_q;
    assign out_tag    = tag_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, random ops against a reference
// model, and hand-written throughput, backpressure, flush and reset sequences.
module tb_alu_multicycle;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_flag;
    logic [4:0]  in_op, in_tag, out_tag;
    logic [31:0] in_a, in_b, out_result;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.XLEN(32), .OP_WIDTH(5), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flag(out_flag), .out_tag(out_tag)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        flag;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic flag, input int lat);
        vec_t v;
        v.op = op[4:0]; v.a = a; v.b = b; v.res = res; v.flag = flag; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model from the op definitions with plain integer arithmetic.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic f, output int lat);
        int          sa, sb;
        longint      p;
        logic [63:0] pu;
        sa = a; sb = b; r = '0; f = 1'b0; lat = 1;
        case (op)
            0:  r = a + b;
            1:  begin r = a - b; f = (a == b); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~(a | b);
            6:  r = a << b[4:0];
            7:  r = a >> b[4:0];
            8:  r = sa >>> b[4:0];
            9:  begin f = (sa < sb); r = {31'b0, f}; end
            10: begin f = (a < b);   r = {31'b0, f}; end
            11: f = (a == b);
            12: f = (a != b);
            13: f = (sa < sb);
            14: f = (sa >= sb);
            15: f = (a < b);
            16: f = (a >= b);
            17: begin pu = {32'b0, a} * {32'b0, b}; r = pu[31:0]; lat = 33; end
            18: begin p = longint'(sa) * longint'(sb); r = p[63:32]; lat = 33; end
            19: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; lat = 33; end
            20: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; lat = 33; end
            21, 23: begin
                if (b == 0)                                   r = (op == 21) ? 32'hFFFF_FFFF : a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = (op == 21) ? a : 32'h0;
                else begin r = (op == 21) ? sa / sb : sa % sb; lat = 33; end
            end
            22, 24: begin
                if (b == 0) r = (op == 22) ? 32'hFFFF_FFFF : a;
                else begin r = (op == 22) ? a / b : a % b; lat = 33; end
            end
            default: ;
        endcase
    endfunction

    // Present a request, wait for accept, then wait for its result (bounded).
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] r, output logic f,
                         output logic [4:0] t, output int lat);
        int w;
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        r = out_result; f = out_flag; t = out_tag;
    endtask

    initial begin
        logic [31:0] r, a, b, er;
        logic        f, ef;
        logic [4:0]  t, op;
        int          lat, elat, cnt;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;

        tbl.push_back(mk(0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1));
        tbl.push_back(mk(1,  32'd5,         32'd5,         32'h0,         1'b1, 1));
        tbl.push_back(mk(1,  32'd7,         32'd5,         32'h2,         1'b0, 1));
        tbl.push_back(mk(8,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1));
        tbl.push_back(mk(10, 32'd1,         32'hFFFF_FFFF, 32'h1,         1'b1, 1));
        tbl.push_back(mk(14, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0, 1));
        tbl.push_back(mk(15, 32'd1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1));
        tbl.push_back(mk(5,  32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1));
        tbl.push_back(mk(25, 32'h1234,      32'h5678,      32'h0,         1'b0, 1));
        tbl.push_back(mk(17, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b0, 33));
        tbl.push_back(mk(18, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 33));
        tbl.push_back(mk(20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33));
        tbl.push_back(mk(19, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 33));
        tbl.push_back(mk(21, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33));
        tbl.push_back(mk(23, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33));
        tbl.push_back(mk(22, 32'd100,       32'd7,         32'd14,        1'b0, 33));
        tbl.push_back(mk(24, 32'd100,       32'd7,         32'd2,         1'b0, 33));
        tbl.push_back(mk(21, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1));
        tbl.push_back(mk(23, 32'd5,         32'd0,         32'd5,         1'b0, 1));
        tbl.push_back(mk(21, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1));
        tbl.push_back(mk(23, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_flag", 32'(out_flag), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i), r, f, t, lat);
            chk($sformatf("vec%0d_op%0d_res", i, tbl[i].op), r, tbl[i].res);
            chk($sformatf("vec%0d_op%0d_flag", i, tbl[i].op), 32'(f), 32'(tbl[i].flag));
            chk($sformatf("vec%0d_op%0d_lat", i, tbl[i].op), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_op%0d_tag", i, tbl[i].op), 32'(t), 32'(i[4:0]));
        end

        for (int i = 0; i < 250; i++) begin
            op = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0:       begin a = $urandom; b = 32'h0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       begin a = $urandom; b = 32'($urandom_range(1, 20)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            model(op, a, b, er, ef, elat);
            issue(op, a, b, 5'(i), r, f, t, lat);
            chk($sformatf("rnd%0d_op%0d_res a=%h b=%h", i, op, a, b), r, er);
            chk($sformatf("rnd%0d_op%0d_flag", i, op), 32'(f), 32'(ef));
            chk($sformatf("rnd%0d_op%0d_lat", i, op), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_op%0d_tag", i, op), 32'(t), 32'(i[4:0]));
        end

        // Back-to-back single-cycle ops: one result per cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            in_op = 5'd0; in_a = 32'(i * 3); in_b = 32'd100; in_tag = 5'(i + 20); in_valid = 1'b1;
            #1;
            chk($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d_res", i), out_result, 32'(i * 3 + 100));
            chk($sformatf("b2b%0d_tag", i), 32'(out_tag), 32'(i + 20));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: result and tag hold while out_ready is low.
        out_ready = 1'b0;
        in_op = 5'd0; in_a = 32'h10; in_b = 32'h20; in_tag = 5'h1A; in_valid = 1'b1;
        #1;
        chk("bp_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_res", k), out_result, 32'h30);
            chk($sformatf("bp%0d_tag", k), 32'(out_tag), 32'h1A);
            chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_op = 5'd1; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd5; in_valid = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_valid", 32'(out_valid), 32'd1);
        chk("bp_new_res", out_result, 32'd0);
        chk("bp_new_flag", 32'(out_flag), 32'd1);
        chk("bp_new_tag", 32'(out_tag), 32'd5);

        // Flush ten cycles into a divide.
        in_op = 5'd21; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("fl_busy_valid", 32'(out_valid), 32'd0);
        chk("fl_busy_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        in_op = 5'd0; in_a = 32'd1; in_b = 32'd2; in_tag = 5'd9; in_valid = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_next_valid", 32'(out_valid), 32'd0);
        #1;
        chk("fl_next_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fl_held_valid", 32'(out_valid), 32'd1);
        chk("fl_held_res", out_result, 32'd3);
        chk("fl_held_tag", 32'(out_tag), 32'd9);
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) cnt++; end
        chk("fl_no_stale_result", 32'(cnt), 32'd0);

        // Reset in the middle of a divide.
        in_op = 5'd22; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'h13; in_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        in_op = 5'd1; in_a = 32'd8; in_b = 32'd3; in_tag = 5'd3; in_valid = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_res", out_result, 32'd0);
        chk("mrst_flag", 32'(out_flag), 32'd0);
        chk("mrst_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        #1;
        chk("mrst_after_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mrst_held_valid", 32'(out_valid), 32'd1);
        chk("mrst_held_res", out_result, 32'd5);
        chk("mrst_held_tag", 32'(out_tag), 32'd3);
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) cnt++; end
        chk("mrst_no_stale_result", 32'(cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
